// File: rtl/gpio_in_debounce.sv
// Per-bit synchronizer + stable-time debouncer with sticky rising-edge events and masked clear.
// Latency: raw_in to db_out is DB_CYCLES+2 edges. No backpressure; the block is free-running.
module gpio_in_debounce #(
    parameter int WIDTH     = 32,
    parameter int DB_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             clr,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] evt,
    output logic             evt_any
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic             clr_q;
    logic             clr_pulse;
    logic [WIDTH-1:0] expire;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr_bits;

    // A bit expires when the synchronized level has differed from db_out long enough.
    always_comb begin
        expire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            expire[i] = (s2[i] != db_out[i]) && (cnt[i] == CNT_MAX);
        end
    end

    assign rise      = expire & s2;
    assign clr_pulse = clr & ~clr_q;
    assign clr_bits  = clr_pulse ? clr_mask : '0;
    assign evt_any   = |evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= '0;
            s2     <= '0;
            db_out <= '0;
            evt    <= '0;
            clr_q  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= raw_in;
            s2    <= s1;
            clr_q <= clr;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == db_out[i]) begin
                    cnt[i] <= '0;
                end else if (expire[i]) begin
                    db_out[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            // Set wins over clear on the same edge.
            evt <= (evt & ~clr_bits) | rise;
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with WIDTH=32, DB_CYCLES=4 (6-edge debounce latency).
module tb_gpio_in_debounce;

    logic        clk;
    logic        rst;
    logic [31:0] raw_in;
    logic        clr;
    logic [31:0] clr_mask;
    logic [31:0] db_out;
    logic [31:0] evt;
    logic        evt_any;

    int checks = 0;
    int errors = 0;

    gpio_in_debounce #(
        .WIDTH     (32),
        .DB_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (raw_in),
        .clr      (clr),
        .clr_mask (clr_mask),
        .db_out   (db_out),
        .evt      (evt),
        .evt_any  (evt_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        raw_in   = '0;
        clr      = 1'b0;
        clr_mask = '0;
        #3;
        check("reset_db", db_out, 32'h0);
        check("reset_evt", evt, 32'h0);
        check("reset_any", {31'b0, evt_any}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: bit 0 press, 6-edge latency
        raw_in[0] = 1'b1;
        step(5);
        check("t1_db_edge5", db_out, 32'h0);
        check("t1_evt_edge5", evt, 32'h0);
        step(1);
        check("t1_db_edge6", db_out, 32'h1);
        check("t1_evt_edge6", evt, 32'h1);
        check("t1_any", {31'b0, evt_any}, 32'h1);

        // 2: 3-cycle glitch on bit 3 is rejected
        raw_in[3] = 1'b1;
        step(3);
        raw_in[3] = 1'b0;
        step(2);
        check("t2_db_mid", db_out, 32'h1);
        step(8);
        check("t2_db_end", db_out, 32'h1);
        check("t2_evt_end", evt, 32'h1);
        check("t2_cnt3", 32'(dut.cnt[3]), 32'h0);

        // 3: clear once while clr held, later press still sets
        clr_mask = 32'h1;
        clr      = 1'b1;
        step(1);
        check("t3_evt_cleared", evt, 32'h0);
        check("t3_any_cleared", {31'b0, evt_any}, 32'h0);
        raw_in[0] = 1'b0;
        step(6);
        check("t3_db_release", db_out, 32'h0);
        check("t3_evt_release", evt, 32'h0);
        raw_in[0] = 1'b1;
        step(6);
        check("t3_db_press", db_out, 32'h1);
        check("t3_evt_reset_while_clr", evt, 32'h1);
        clr = 1'b0;
        step(1);

        // 4: clr rising edge coincides with bit-5 expiry
        raw_in[5] = 1'b1;
        step(5);
        check("t4_evt_before", evt, 32'h1);
        clr_mask = 32'h20;
        clr      = 1'b1;
        step(1);
        check("t4_db_expiry", db_out, 32'h21);
        check("t4_set_beats_clr", evt, 32'h21);
        clr = 1'b0;
        step(1);
        clr = 1'b1;
        step(1);
        check("t4_later_clear", evt, 32'h1);
        clr = 1'b0;

        // 5: falling transition leaves evt alone
        raw_in[7] = 1'b1;
        step(6);
        check("t5_db_high", db_out, 32'hA1);
        check("t5_evt_high", evt, 32'h81);
        raw_in[7] = 1'b0;
        step(5);
        check("t5_db_fall_edge5", db_out, 32'hA1);
        step(1);
        check("t5_db_fall_edge6", db_out, 32'h21);
        check("t5_evt_kept", evt, 32'h81);

        // 6: async reset mid-count on bit 2
        raw_in[2] = 1'b1;
        step(4);
        check("t6_cnt2", 32'(dut.cnt[2]), 32'h2);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_db", db_out, 32'h0);
        check("t6_rst_evt", evt, 32'h0);
        check("t6_rst_any", {31'b0, evt_any}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(5);
        check("t6_db_edge5", db_out, 32'h0);
        step(1);
        check("t6_db_edge6", db_out, 32'h25);
        check("t6_evt_edge6", evt, 32'h25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
